// File: rtl/bcd_modn_counter.sv
// bcd_modn_counter: packed-BCD modulo-N counter with enable, synchronous load,
// terminal-count output for cascading and a registered wrap pulse.
// State changes on the falling edge of clock; reset_n is asynchronous, active-low.
// Optional feature macro: BCD_COUNTER_DOWN_EN adds the decrement direction
// (the up port is ignored and treated as 1 when the macro is undefined).
// Handshake: no valid/ready pair; enable qualifies one step per falling edge,
// load takes priority over enable, and tc is the combinational "next step wraps"
// flag meant to drive the enable of the next cascaded stage.
module bcd_modn_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap
);

  localparam int W = 4 * DIGITS;

  // Elaboration-time binary to packed-BCD conversion of a constant.
  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Largest count value (MODULUS-1) in BCD; also the load acceptance bound.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic [W-1:0] inc_val;
  logic         inc_carry;
  logic         digits_ok;
  logic         load_ok;
  logic         at_max;
  logic         at_bound;
  logic         dir_up;

`ifdef BCD_COUNTER_DOWN_EN
  logic [W-1:0] dec_val;
  logic         dec_borrow;
  logic         at_zero;

  assign dir_up  = up;
  assign at_zero = (count_q == '0);

  // BCD minus one: a 0 digit becomes 9 and borrows from the next digit.
  always_comb begin
    dec_val    = count_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  assign at_bound = dir_up ? at_max : at_zero;
`else
  logic unused_up;

  assign dir_up    = 1'b1;
  assign unused_up = up;
  assign at_bound  = at_max;
`endif

  assign at_max = (count_q == MAX_BCD);

  // BCD plus one: a 9 digit becomes 0 and carries into the next digit.
  always_comb begin
    inc_val   = count_q;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // Load value is accepted only if all digits are decimal and it is in range;
  // for valid BCD, unsigned packed compare equals decimal compare.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok && (load_val <= MAX_BCD);
  end

  // Next state: load > enable > hold; wrap flags a boundary step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_ok ? load_val : '0;
    end else if (enable) begin
`ifdef BCD_COUNTER_DOWN_EN
      if (dir_up) begin
        count_d = at_max ? '0 : inc_val;
      end else begin
        count_d = at_zero ? MAX_BCD : dec_val;
      end
`else
      count_d = at_max ? '0 : inc_val;
`endif
      wrap_d = at_bound;
    end
  end

  // Count and wrap registers, falling-edge clocked, async active-low reset.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign tc    = enable & ~load & at_bound;

endmodule
